// File: rtl/sub_bytes.sv
// AES SubBytes stage: 16 independent forward S-box lookups on a 128-bit state,
// registered once, so the result appears one clock after the input is sampled.

module sub_bytes_lane (
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out
);
    // FIPS-197 forward S-box. Element 0 is listed first.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign byte_out = SBOX[byte_in];
endmodule

module sub_bytes (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_in,
    input  logic [127:0] data_in,
    output logic         valid_out,
    output logic [127:0] data_out
);
    localparam int NUM_LANES = 16;
    localparam int VEC_W     = 8;

    logic [NUM_LANES-1:0][VEC_W-1:0] in_bytes;
    logic [NUM_LANES-1:0][VEC_W-1:0] sub_bytes_c;

    assign in_bytes = data_in;

    sub_bytes_lane u_lane [NUM_LANES-1:0] (
        .byte_in  (in_bytes),
        .byte_out (sub_bytes_c)
    );

    // data_out only loads on an accepted input so it holds across idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in)
                data_out <= sub_bytes_c;
        end
    end
endmodule

// File: tb/tb_sub_bytes.sv
// Self-checking bench for sub_bytes; the reference S-box is derived from
// GF(2^8) inversion plus the AES affine map rather than a lookup table.

module tb_sub_bytes;
    logic         clk = 1'b0;
    logic         reset;
    logic         valid_in;
    logic [127:0] data_in;
    logic         valid_out;
    logic [127:0] data_out;

    int errors = 0;
    int checks = 0;

    logic [7:0]   ref_tab [256];
    logic [127:0] exp_data;

    sub_bytes dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] v);
        logic [7:0] inv = 8'h01;
        if (v == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, v);
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_tab[s[8*i +: 8]];
        return r;
    endfunction

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b1; data_in = 128'hffff;
        step(); step();
        reset = 1'b0; valid_in = 1'b0;
        step();
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        checks++;
        if (data_out !== 128'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_out); end
        exp_data = 128'h0;
    endtask

    task automatic test_vector();
        valid_in = 1'b1; data_in = 128'h58cf0bfc4d7c72d958cf0bfc4d7c72d9;
        step();
        valid_in = 1'b0; data_in = 128'h0123456789abcdef0123456789abcdef;
        checks++;
        if (valid_out !== 1'b1) begin errors++; $display("FAIL vec_valid got=%b exp=1", valid_out); end
        checks++;
        if (data_out !== 128'h6a8a2bb0e31040356a8a2bb0e3104035) begin
            errors++; $display("FAIL vec_data got=%h exp=6a8a2bb0e31040356a8a2bb0e3104035", data_out);
        end
        step();
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL vec_idle_valid got=%b exp=0", valid_out); end
        checks++;
        if (data_out !== 128'h6a8a2bb0e31040356a8a2bb0e3104035) begin
            errors++; $display("FAIL vec_hold got=%h exp=6a8a2bb0e31040356a8a2bb0e3104035", data_out);
        end
        exp_data = 128'h6a8a2bb0e31040356a8a2bb0e3104035;
    endtask

    task automatic test_known();
        logic [127:0] ins  [3] = '{128'h0, {16{8'hff}}, 128'h000102030405060708090a0b0c0d0e0f};
        logic [127:0] outs [3] = '{{16{8'h63}}, {16{8'h16}}, 128'h637c777bf26b6fc53001672bfed7ab76};
        for (int k = 0; k < 3; k++) begin
            valid_in = 1'b1; data_in = ins[k];
            step();
            valid_in = 1'b0;
            checks++;
            if (valid_out !== 1'b1 || data_out !== outs[k]) begin
                errors++; $display("FAIL known_%0d got=%b/%h exp=1/%h", k, valid_out, data_out, outs[k]);
            end
            checks++;
            if (data_out !== model(ins[k])) begin
                errors++; $display("FAIL model_%0d got=%h exp=%h", k, data_out, model(ins[k]));
            end
            step();
        end
        exp_data = outs[2];
    endtask

    task automatic test_back_to_back();
        valid_in = 1'b1; data_in = 128'h0;
        step();
        data_in = {16{8'h53}};
        checks++;
        if (valid_out !== 1'b1 || data_out !== {16{8'h63}}) begin
            errors++; $display("FAIL b2b_first got=%b/%h exp=1/%h", valid_out, data_out, {16{8'h63}});
        end
        step();
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 1'b1 || data_out !== {16{8'hed}}) begin
            errors++; $display("FAIL b2b_second got=%b/%h exp=1/%h", valid_out, data_out, {16{8'hed}});
        end
        step();
        exp_data = {16{8'hed}};
    endtask

    task automatic test_random();
        logic exp_v;
        for (int n = 0; n < 300; n++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            data_in  = {$urandom, $urandom, $urandom, $urandom};
            exp_v = valid_in;
            if (valid_in) exp_data = model(data_in);
            step();
            checks++;
            if (valid_out !== exp_v || data_out !== exp_data) begin
                errors++; $display("FAIL rand_%0d got=%b/%h exp=%b/%h", n, valid_out, data_out, exp_v, exp_data);
            end
        end
        valid_in = 1'b0;
        step();
    endtask

    task automatic test_reset_priority();
        valid_in = 1'b1; data_in = {16{8'h11}};
        step();
        reset = 1'b1; data_in = {16{8'h22}};
        step();
        reset = 1'b0; valid_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0 || data_out !== 128'h0) begin
            errors++; $display("FAIL rst_prio got=%b/%h exp=0/0", valid_out, data_out);
        end
        step();
        checks++;
        if (valid_out !== 1'b0 || data_out !== 128'h0) begin
            errors++; $display("FAIL rst_after got=%b/%h exp=0/0", valid_out, data_out);
        end
        valid_in = 1'b1; data_in = 128'hdeadbeef00112233445566778899aabb;
        step();
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 1'b1 || data_out !== model(128'hdeadbeef00112233445566778899aabb)) begin
            errors++; $display("FAIL rst_resume got=%b/%h exp=1/%h", valid_out, data_out,
                               model(128'hdeadbeef00112233445566778899aabb));
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_tab[i] = sbox_model(8'(i));
        reset = 1'b0; valid_in = 1'b0; data_in = '0; exp_data = '0;
        #2;
        test_reset();
        test_vector();
        test_known();
        test_back_to_back();
        test_random();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
